// File: rtl/io_uart_pkg.sv
// Shared definitions for the port-mapped UART: register offsets, status layout
// and the transmit/receive state encodings.
package io_uart_pkg;

   localparam logic [7:0] IO_DATA = 8'd0;
   localparam logic [7:0] IO_STAT = 8'd1;
   localparam logic [7:0] IO_DIV  = 8'd2;

   typedef struct packed {
      logic [9:0] rsvd;
      logic       tx_overflow;
      logic       frame_err;
      logic       tx_idle;
      logic       tx_full;
      logic       rx_overrun;
      logic       rx_valid;
   } status_t;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   // Half a bit period for the receiver's start-bit centring, never below one cycle.
   function automatic logic [15:0] half_div(input logic [15:0] div);
      return (div < 16'd2) ? 16'd1 : (div >> 1);
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with full/empty flags; a push into a full FIFO is accepted
// only when a pop on the same edge frees a slot.
module io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic do_push, do_pop;

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/io_uart.sv
// Port-mapped 8N1 UART: data/status/divisor registers, FIFO-backed transmitter
// and a receiver with a single-byte holding register.
module io_uart
   import io_uart_pkg::*;
#(
   parameter logic [7:0]  BASE      = 8'h10,
   parameter logic [15:0] DIV_RESET = 16'd434,
   parameter int          TX_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_oe,
   input  logic        io_we,
   input  logic [7:0]  io_port,
   input  logic [15:0] io_in,
   output logic [15:0] io_out,
   input  logic        rxd,
   output logic        txd,
   output logic [15:0] disp_status
);

   logic [7:0]  offset;
   logic        hit, oe_q, rd_fire, rd_data, rd_stat, wr_data, wr_div;
   logic [15:0] div_q;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        txd_q, txd_d;
   logic        rx_s1_q, rx_s2_q, rx_s3_q;
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
   logic        rx_done, rx_stop;
   logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
   logic        frame_err_q, frame_err_d, tx_overflow_q, tx_overflow_d, valid_kept;
   status_t     status;

   // Offset arithmetic wraps, so a BASE near 8'hFF still decodes exactly three ports.
   assign offset  = io_port - BASE;
   assign hit     = (offset <= IO_DIV);
   assign rd_fire = io_oe && !oe_q && hit;
   assign rd_data = rd_fire && (offset == IO_DATA);
   assign rd_stat = rd_fire && (offset == IO_STAT);
   assign wr_data = io_we && hit && (offset == IO_DATA);
   assign wr_div  = io_we && hit && (offset == IO_DIV);

   io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_data),
      .wdata_i (io_in[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      fifo_pop   = 1'b0;
      if (tx_state_q != TX_IDLE && tx_cnt_q != 16'd0) tx_cnt_d = tx_cnt_q - 16'd1;
      case (tx_state_q)
         TX_IDLE: if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_rdata;
            tx_cnt_d   = div_q - 16'd1;
            tx_state_d = TX_START;
         end
         TX_START: if (tx_cnt_q == 16'd0) begin
            tx_bit_d   = 3'd0;
            tx_cnt_d   = div_q - 16'd1;
            tx_state_d = TX_DATA;
         end
         TX_DATA: if (tx_cnt_q == 16'd0) begin
            tx_cnt_d = div_q - 16'd1;
            if (tx_bit_q == 3'd7) begin
               tx_state_d = TX_STOP;
            end else begin
               tx_bit_d   = tx_bit_q + 3'd1;
               tx_shift_d = tx_shift_q >> 1;
            end
         end
         TX_STOP: if (tx_cnt_q == 16'd0) begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               tx_shift_d = fifo_rdata;
               tx_cnt_d   = div_q - 16'd1;
               tx_state_d = TX_START;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      case (tx_state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      rx_stop    = 1'b0;
      if (rx_state_q != RX_IDLE && rx_cnt_q != 16'd0) rx_cnt_d = rx_cnt_q - 16'd1;
      case (rx_state_q)
         RX_IDLE: if (rx_s3_q && !rx_s2_q) begin
            rx_cnt_d   = half_div(div_q) - 16'd1;
            rx_state_d = RX_START;
         end
         RX_START: if (rx_cnt_q == 16'd0) begin
            rx_bit_d   = 3'd0;
            rx_cnt_d   = div_q - 16'd1;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == 16'd0) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_cnt_d   = div_q - 16'd1;
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_cnt_q == 16'd0) begin
            rx_done    = 1'b1;
            rx_stop    = rx_s2_q;
            rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // A data read on the completing edge empties the holder first, so the new byte lands cleanly.
   always_comb begin
      valid_kept    = rx_valid_q && !rd_data;
      rx_valid_d    = valid_kept;
      rx_byte_d     = rx_byte_q;
      rx_overrun_d  = rx_overrun_q  && !rd_stat;
      frame_err_d   = frame_err_q   && !rd_stat;
      tx_overflow_d = (tx_overflow_q && !rd_stat) || (wr_data && fifo_full && !fifo_pop);
      if (rx_done) begin
         if (!rx_stop)        frame_err_d  = 1'b1;
         else if (valid_kept) rx_overrun_d = 1'b1;
         else begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         oe_q          <= 1'b0;
         div_q         <= DIV_RESET;
         tx_state_q    <= TX_IDLE;
         tx_cnt_q      <= '0;
         tx_bit_q      <= '0;
         tx_shift_q    <= '0;
         txd_q         <= 1'b1;
         {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
         rx_state_q    <= RX_IDLE;
         rx_cnt_q      <= '0;
         rx_bit_q      <= '0;
         rx_shift_q    <= '0;
         rx_byte_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_overrun_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         tx_overflow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         oe_q <= io_oe;
         if (wr_div) div_q <= (io_in == 16'd0) ? 16'd1 : io_in;
         tx_state_q    <= tx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_bit_q      <= tx_bit_d;
         tx_shift_q    <= tx_shift_d;
         txd_q         <= txd_d;
         {rx_s1_q, rx_s2_q, rx_s3_q} <= {rxd, rx_s1_q, rx_s2_q};
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         rx_byte_q     <= rx_byte_d;
         rx_valid_q    <= rx_valid_d;
         rx_overrun_q  <= rx_overrun_d;
         frame_err_q   <= frame_err_d;
         tx_overflow_q <= tx_overflow_d;
      end
   end

   always_comb begin
      status             = '0;
      status.rx_valid    = rx_valid_q;
      status.rx_overrun  = rx_overrun_q;
      status.tx_full     = fifo_full;
      status.tx_idle     = fifo_empty && (tx_state_q == TX_IDLE);
      status.frame_err   = frame_err_q;
      status.tx_overflow = tx_overflow_q;
   end

   always_comb begin
      io_out = '0;
      if (io_oe && hit) begin
         case (offset)
            IO_DATA: io_out = {8'h00, rx_byte_q};
            IO_STAT: io_out = status;
            IO_DIV:  io_out = div_q;
            default: io_out = '0;
         endcase
      end
   end

   assign txd         = txd_q;
   assign disp_status = status;

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: directed steps plus randomized TX/RX bytes
// compared against a frame-level serial model.
module tb_io_uart;

   localparam logic [7:0] P_DATA = 8'h10;
   localparam logic [7:0] P_STAT = 8'h11;
   localparam logic [7:0] P_DIV  = 8'h12;

   logic        clk = 1'b0;
   logic        rst, io_oe, io_we, rxd;
   logic [7:0]  io_port;
   logic [15:0] io_in, io_out, disp_status;
   logic        txd;

   int vectors = 0;
   int miscompares = 0;

   // Serial-line monitor state: decoded TX frames as {start, stop, byte}.
   bit         mon_en = 1'b0;
   int         mon_div = 434;
   logic [9:0] mon_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] mon_byte;
   logic       mon_start, mon_stop;
   int         mon_d;

   io_uart dut (
      .clk         (clk),
      .rst         (rst),
      .io_oe       (io_oe),
      .io_we       (io_we),
      .io_port     (io_port),
      .io_in       (io_in),
      .io_out      (io_out),
      .rxd         (rxd),
      .txd         (txd),
      .disp_status (disp_status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] stat_word(input int valid, input int ovr, input int full,
                                             input int idle, input int ferr, input int tovf);
      return 16'(valid + 2 * ovr + 4 * full + 8 * idle + 16 * ferr + 32 * tovf);
   endfunction

   task automatic cpu_write(input logic [7:0] port, input logic [15:0] data);
      @(negedge clk);
      io_we = 1'b1; io_port = port; io_in = data;
      @(negedge clk);
      io_we = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] port, output logic [15:0] data);
      @(negedge clk);
      io_oe = 1'b1; io_port = port;
      #1 data = io_out;
      @(negedge clk);
      io_oe = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [7:0] port, input logic [15:0] exp);
      logic [15:0] v;
      cpu_read(port, v);
      check(tag, v, exp);
   endtask

   task automatic set_div(input logic [15:0] d);
      cpu_write(P_DIV, d);
      mon_div = (d == 16'd0) ? 1 : int'(d);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
      @(negedge clk);
      rxd = 1'b0;
      repeat (d) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (d) @(negedge clk);
      end
      rxd = stop;
      repeat (d) @(negedge clk);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Called at the negedge just after the frame's start edge; checks first and last cycle of each bit.
   task automatic tx_expect_frame(input logic [7:0] b, input int d, input string tag);
      logic e;
      for (int k = 0; k < 10; k++) begin
         e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
         check($sformatf("%s_bit%0d_first", tag, k), {15'd0, txd}, {15'd0, e});
         repeat (d - 1) @(negedge clk);
         check($sformatf("%s_bit%0d_last", tag, k), {15'd0, txd}, {15'd0, e});
         @(negedge clk);
      end
   endtask

   task automatic wait_tx_idle(input string tag, input int budget);
      int n = 0;
      while (disp_status[3] !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, {15'd0, disp_status[3]}, 16'd1);
   endtask

   task automatic compare_tx(input string tag);
      check($sformatf("%s_count", tag), 16'(mon_q.size()), 16'(exp_q.size()));
      while (exp_q.size() > 0 && mon_q.size() > 0)
         check($sformatf("%s_frame", tag), {6'd0, mon_q.pop_front()}, {6'd0, 2'b01, exp_q.pop_front()});
      mon_q.delete();
      exp_q.delete();
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && txd === 1'b0) begin
            mon_d = mon_div;
            repeat (mon_d / 2) @(negedge clk);
            mon_start = txd;
            for (int i = 0; i < 8; i++) begin
               repeat (mon_d) @(negedge clk);
               mon_byte[i] = txd;
            end
            repeat (mon_d) @(negedge clk);
            mon_stop = txd;
            mon_q.push_back({mon_start, mon_stop, mon_byte});
         end
      end
   end

   initial begin
      logic [7:0] b;
      int d, n, lows;

      rst = 1'b0; io_oe = 1'b0; io_we = 1'b0; io_port = 8'h00; io_in = 16'h0000; rxd = 1'b1;
      #12;
      check("reset_txd", {15'd0, txd}, 16'd1);
      check("reset_status", disp_status, 16'h0008);
      check("reset_io_out", io_out, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      read_check("reset_div", P_DIV, 16'd434);
      read_check("unmapped_above", 8'h13, 16'h0000);
      read_check("unmapped_below", 8'h0F, 16'h0000);

      // Single TX with exact bit timing.
      set_div(16'd4);
      cpu_write(P_DATA, 16'h00A5);
      check("tx_before_e1", {15'd0, txd}, 16'd1);
      @(negedge clk);
      tx_expect_frame(8'hA5, 4, "single");
      check("single_idle_status", disp_status, 16'h0008);
      read_check("single_stat_read", P_STAT, 16'h0008);

      // FIFO overflow: six back-to-back writes, sixth dropped.
      mon_en = 1'b1;
      mon_q.delete();
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         io_we = 1'b1; io_port = P_DATA; io_in = 16'(i);
         if (i <= 5) exp_q.push_back(8'(i));
      end
      @(negedge clk);
      io_we = 1'b0;
      read_check("ovf_status", P_STAT, stat_word(0, 0, 1, 0, 0, 1));
      check("ovf_cleared", disp_status, stat_word(0, 0, 1, 0, 0, 0));
      wait_tx_idle("ovf_drain", 6 * 10 * 4 + 20);
      compare_tx("ovf");

      // Divisor 0 behaves as 1.
      set_div(16'd0);
      read_check("div_zero_reads_one", P_DIV, 16'd1);
      exp_q.push_back(8'h3A);
      cpu_write(P_DATA, 16'h003A);
      wait_tx_idle("div1_drain", 40);
      repeat (4) @(negedge clk);
      compare_tx("div1");

      // Randomized TX bursts within FIFO capacity.
      for (int r = 0; r < 3; r++) begin
         d = $urandom_range(1, 6);
         set_div(16'(d));
         n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            cpu_write(P_DATA, {8'h00, b});
         end
         wait_tx_idle($sformatf("rand_tx%0d_drain", r), 6 * 10 * d + 40);
         repeat (2) @(negedge clk);
         compare_tx($sformatf("rand_tx%0d", r));
         read_check($sformatf("rand_tx%0d_status", r), P_STAT, stat_word(0, 0, 0, 1, 0, 0));
      end
      mon_en = 1'b0;

      // RX with overrun.
      set_div(16'd8);
      send_rx(8'h3C, 1'b1, 8);
      check("rx_valid_first", disp_status, stat_word(1, 0, 0, 1, 0, 0));
      send_rx(8'hC3, 1'b1, 8);
      read_check("rx_overrun_status", P_STAT, stat_word(1, 1, 0, 1, 0, 0));
      read_check("rx_data_kept", P_DATA, 16'h003C);
      read_check("rx_after_read", P_STAT, stat_word(0, 0, 0, 1, 0, 0));

      // Frame error and false start.
      send_rx(8'h55, 1'b0, 8);
      read_check("frame_err_status", P_STAT, stat_word(0, 0, 0, 1, 1, 0));
      read_check("frame_err_cleared", P_STAT, stat_word(0, 0, 0, 1, 0, 0));
      @(negedge clk);
      rxd = 1'b0;
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      read_check("glitch_no_flags", P_STAT, stat_word(0, 0, 0, 1, 0, 0));

      // Randomized RX bytes.
      for (int r = 0; r < 5; r++) begin
         d = $urandom_range(4, 12);
         set_div(16'(d));
         b = 8'($urandom);
         send_rx(b, 1'b1, d);
         read_check($sformatf("rand_rx%0d_status", r), P_STAT, stat_word(1, 0, 0, 1, 0, 0));
         read_check($sformatf("rand_rx%0d_data", r), P_DATA, {8'h00, b});
         read_check($sformatf("rand_rx%0d_clear", r), P_STAT, stat_word(0, 0, 0, 1, 0, 0));
      end

      // Reset during TX data bit 3 with a byte still queued.
      set_div(16'd4);
      cpu_write(P_DATA, 16'h0000);
      cpu_write(P_DATA, 16'h0000);
      repeat (17) @(negedge clk);
      check("mid_frame_txd_low", {15'd0, txd}, 16'd0);
      #1 rst = 1'b0;
      #1;
      check("mid_reset_txd", {15'd0, txd}, 16'd1);
      check("mid_reset_status", disp_status, 16'h0008);
      @(negedge clk);
      rst = 1'b1;
      read_check("mid_reset_div", P_DIV, 16'd434);
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check("no_residual_frame", 16'(lows), 16'd0);
      check("post_reset_status", disp_status, 16'h0008);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
